mdio_master: RTL and testbench

//  Parametrised IEEE 802.3 Clause-22 MDIO management master for the Ethernet MAC subsystem.

---
 rtl/mdio_pkg.sv | 14 +
 rtl/mdio_clkgen.sv | 40 ++++
 rtl/mdio_master.sv | 157 +++++++++++++++
 tb/tb_mdio_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int HDR_LEN  = 14;
  localparam int TA_LEN   = 2;
  localparam int DATA_LEN = 16;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, END} state_t;

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: each bit is a low half then a high half, each div clocks long.
// fall_stb marks the clock whose edge begins a low half; rise_stb the last clock of a low half.
module mdio_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             mdc,
  output logic             fall_stb,
  output logic             rise_stb
);

  logic [DIV_W-1:0] cnt_reg;
  logic             mdc_reg;
  logic             term;

  // div is never 0 here; the top clamps it when latching the command.
  assign term     = (cnt_reg == div - DIV_W'(1));
  assign fall_stb = en & mdc_reg & term;
  assign rise_stb = en & ~mdc_reg & term;
  assign mdc      = mdc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      mdc_reg <= 1'b0;
    end else if (!en) begin
      cnt_reg <= '0;
      mdc_reg <= 1'b0;
    end else if (term) begin
      cnt_reg <= '0;
      mdc_reg <= ~mdc_reg;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises read/write commands into MDC/MDIO frames
// and returns read data plus a no-PHY flag from the second turnaround bit.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int PRE_LEN   = 32,
  parameter int IDLE_BITS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [4:0]       cmd_phy,
  input  logic [4:0]       cmd_reg,
  input  logic [15:0]      cmd_wdata,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_no_pre,
  output logic             rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic             mdc,
  output logic             mdo,
  output logic             mdoEn,
  input  logic             mdi
);

  state_t           state_reg, state_next;
  logic [5:0]       cnt_reg, cnt_next;
  logic [31:0]      tx_reg, tx_next;
  logic             write_reg, write_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             mdo_reg, mdo_next;
  logic             mdo_en_reg, mdo_en_next;
  logic [15:0]      rx_reg, rsp_rdata_reg;
  logic             err_reg, rsp_err_reg, rsp_valid_reg;
  logic             accept, done, fall_stb, rise_stb;

  assign accept    = (state_reg == IDLE) && cmd_valid;
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign mdo       = mdo_reg;
  assign mdoEn     = mdo_en_reg;

  mdio_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clock    (clock),
    .reset    (reset),
    .en       (busy),
    .div      (div_reg),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tx_next     = tx_reg;
    write_next  = write_reg;
    div_next    = div_reg;
    done        = 1'b0;
    mdo_next    = 1'b1;
    mdo_en_next = 1'b0;

    if (accept) begin
      write_next = cmd_write;
      div_next   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      tx_next    = {ST, cmd_write ? OP_WRITE : OP_READ, cmd_phy, cmd_reg,
                    cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
      if (cfg_no_pre) begin
        state_next = HDR;
        cnt_next   = 6'(HDR_LEN);
      end else begin
        state_next = PRE;
        cnt_next   = 6'(PRE_LEN);
      end
    end else if (fall_stb) begin
      // The bit on the wire is always tx_reg[31] outside the preamble.
      if (state_reg != PRE) tx_next = {tx_reg[30:0], 1'b1};
      if (cnt_reg > 6'd1) begin
        cnt_next = cnt_reg - 6'd1;
      end else begin
        case (state_reg)
          PRE:  begin state_next = HDR;  cnt_next = 6'(HDR_LEN);  end
          HDR:  begin state_next = TA;   cnt_next = 6'(TA_LEN);   end
          TA:   begin state_next = DATA; cnt_next = 6'(DATA_LEN); end
          DATA: begin
            if (IDLE_BITS == 0) begin
              state_next = IDLE;
              done       = 1'b1;
            end else begin
              state_next = END;
              cnt_next   = 6'(IDLE_BITS);
            end
          end
          END:  begin state_next = IDLE; done = 1'b1; end
          default: state_next = IDLE;
        endcase
      end
    end

    case (state_next)
      PRE: mdo_en_next = 1'b1;
      HDR: begin
        mdo_next    = tx_next[31];
        mdo_en_next = 1'b1;
      end
      TA, DATA: begin
        mdo_next    = tx_next[31];
        mdo_en_next = write_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      tx_reg        <= '0;
      write_reg     <= 1'b0;
      div_reg       <= DIV_W'(1);
      mdo_reg       <= 1'b1;
      mdo_en_reg    <= 1'b0;
      rx_reg        <= '0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tx_reg        <= tx_next;
      write_reg     <= write_next;
      div_reg       <= div_next;
      mdo_reg       <= mdo_next;
      mdo_en_reg    <= mdo_en_next;
      rsp_valid_reg <= done;
      if (accept) begin
        err_reg <= 1'b0;
      end else if (rise_stb) begin
        if (state_reg == TA && cnt_reg == 6'd1) err_reg <= mdi;
        if (state_reg == DATA) rx_reg <= {rx_reg[14:0], mdi};
      end
      if (done) begin
        rsp_err_reg <= !write_reg && err_reg;
        if (!write_reg) rsp_rdata_reg <= rx_reg;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame bits, timing, read data, no-PHY error,
// back-to-back commands and asynchronous reset mid-frame.
module tb_mdio_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy = '0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic [7:0]  cfg_div = 8'd1;
  logic        cfg_no_pre = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy, mdc, mdo, mdoEn, mdi;

  int vec = 0;
  int miscmp = 0;

  // MDC-edge monitor: records the driven bit at every rising MDC edge.
  logic    mon_mdo [1024];
  logic    mon_en  [1024];
  longint  mon_t   [1024];
  int      mon_n = 0;
  int      mon_base = 0;
  logic [0:127] phy_seq = '1;
  int      mdi_idx;

  always #5 clock = ~clock;

  assign mdi_idx = mon_n - mon_base;
  assign mdi = (mdi_idx >= 0 && mdi_idx < 128) ? phy_seq[mdi_idx[6:0]] : 1'b1;

  always @(posedge mdc) begin
    if (mon_n < 1024) begin
      mon_mdo[mon_n] <= mdo;
      mon_en[mon_n]  <= mdoEn;
      mon_t[mon_n]   <= $time;
    end
    mon_n <= mon_n + 1;
  end

  mdio_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .cfg_div(cfg_div), .cfg_no_pre(cfg_no_pre),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mdc(mdc), .mdo(mdo), .mdoEn(mdoEn), .mdi(mdi)
  );

  task automatic start_cmd(input logic w, input logic [4:0] p, input logic [4:0] r,
                           input logic [15:0] d, input logic [7:0] dv, input logic np);
    cmd_write = w; cmd_phy = p; cmd_reg = r; cmd_wdata = d;
    cfg_div = dv; cfg_no_pre = np;
    cmd_valid = 1'b1;
    mon_base = mon_n;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  // Cycle index of rsp_valid, counting the cycle after the accept edge as 1; -1 on timeout.
  task automatic wait_rsp(input int limit, output int n);
    n = 1;
    while (rsp_valid !== 1'b1 && n <= limit) begin
      @(posedge clock); #1;
      n++;
    end
    if (n > limit) n = -1;
  endtask

  // Masked mdo bits, enable bits and min/max rise-to-rise spacing (in clocks) of a frame.
  task automatic grab(input int first, input int cnt, input int skip,
                      output logic [0:127] m, output logic [0:127] e,
                      output int pmin, output int pmax);
    m = '0; e = '0; pmin = 1000000; pmax = 0;
    for (int i = 0; i < cnt && i < 128; i++) begin
      m[i] = mon_mdo[first + i] & mon_en[first + i];
      e[i] = mon_en[first + i];
      if (i > 0 && i != skip) begin
        int d;
        d = int'((mon_t[first + i] - mon_t[first + i - 1]) / 10);
        if (d < pmin) pmin = d;
        if (d > pmax) pmax = d;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    vec++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdo, mdoEn} !==
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miscmp++;
      $display("FAIL reset_values: got rdy=%b vld=%b rdata=%h err=%b busy=%b mdc=%b mdo=%b en=%b, want 1 0 0000 0 0 0 1 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdo, mdoEn);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    vec++;
    if ({cmd_ready, busy, mdc} !== 3'b100) begin
      miscmp++;
      $display("FAIL reset_release_idle: got rdy/busy/mdc=%b want 100", {cmd_ready, busy, mdc});
    end
  endtask

  task automatic check_write_1140(input string tag);
    int n, pmin, pmax;
    logic [0:127] m, e;
    start_cmd(1'b1, 5'd1, 5'd0, 16'h1140, 8'd1, 1'b0);
    vec++;
    if ({mdoEn, mdo, busy, cmd_ready} !== 4'b1110) begin
      miscmp++;
      $display("FAIL %s_first_bit: got en/mdo/busy/rdy=%b want 1110", tag, {mdoEn, mdo, busy, cmd_ready});
    end
    wait_rsp(2000, n);
    vec++;
    if (n !== 131) begin
      miscmp++;
      $display("FAIL %s_latency: got %0d want 131", tag, n);
    end
    vec++;
    if (rsp_err !== 1'b0) begin
      miscmp++;
      $display("FAIL %s_err: got %b want 0", tag, rsp_err);
    end
    vec++;
    if (mon_n - mon_base !== 65) begin
      miscmp++;
      $display("FAIL %s_mdc_cycles: got %0d want 65", tag, mon_n - mon_base);
    end
    grab(mon_base, 65, -1, m, e, pmin, pmax);
    vec++;
    if (m !== {64'hFFFF_FFFF_5082_1140, 64'h0}) begin
      miscmp++;
      $display("FAIL %s_bits: got %h want %h", tag, m, {64'hFFFF_FFFF_5082_1140, 64'h0});
    end
    vec++;
    if (e !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}) begin
      miscmp++;
      $display("FAIL %s_enable: got %h want %h", tag, e, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    end
    vec++;
    if (pmin !== 2 || pmax !== 2) begin
      miscmp++;
      $display("FAIL %s_mdc_period: got min %0d max %0d want 2", tag, pmin, pmax);
    end
    @(posedge clock); #1;
    vec++;
    if ({rsp_valid, mdc, mdo, mdoEn, cmd_ready} !== 5'b00101) begin
      miscmp++;
      $display("FAIL %s_after_frame: got vld/mdc/mdo/en/rdy=%b want 00101", tag, {rsp_valid, mdc, mdo, mdoEn, cmd_ready});
    end
  endtask

  task automatic test_write_pre;
    check_write_1140("write_pre");
  endtask

  task automatic test_read;
    int n, pmin, pmax;
    logic [0:127] m, e;
    phy_seq = {{46{1'b1}}, 2'b10, 16'h796D, {64{1'b1}}};
    start_cmd(1'b0, 5'd3, 5'd2, 16'h0000, 8'd4, 1'b0);
    wait_rsp(5000, n);
    vec++;
    if (n !== 521) begin
      miscmp++;
      $display("FAIL read_latency: got %0d want 521", n);
    end
    vec++;
    if (rsp_rdata !== 16'h796D || rsp_err !== 1'b0) begin
      miscmp++;
      $display("FAIL read_data: got %h err %b want 796d err 0", rsp_rdata, rsp_err);
    end
    grab(mon_base, 65, -1, m, e, pmin, pmax);
    vec++;
    if (m !== {32'hFFFF_FFFF, 16'h6188, 80'h0}) begin
      miscmp++;
      $display("FAIL read_bits: got %h want %h", m, {32'hFFFF_FFFF, 16'h6188, 80'h0});
    end
    vec++;
    if (e !== {32'hFFFF_FFFF, 16'hFFFC, 80'h0}) begin
      miscmp++;
      $display("FAIL read_enable: got %h want %h", e, {32'hFFFF_FFFF, 16'hFFFC, 80'h0});
    end
    vec++;
    if (pmin !== 8 || pmax !== 8) begin
      miscmp++;
      $display("FAIL read_mdc_period: got min %0d max %0d want 8", pmin, pmax);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_no_phy;
    int n;
    int extra;
    phy_seq = '1;
    start_cmd(1'b0, 5'd9, 5'd4, 16'h0000, 8'd2, 1'b1);
    wait_rsp(2000, n);
    vec++;
    if (n !== 133) begin
      miscmp++;
      $display("FAIL nophy_latency: got %0d want 133", n);
    end
    vec++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 16'hFFFF) begin
      miscmp++;
      $display("FAIL nophy_rsp: got err %b rdata %h want err 1 rdata ffff", rsp_err, rsp_rdata);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1) extra++;
    end
    vec++;
    if (extra !== 0) begin
      miscmp++;
      $display("FAIL nophy_single_pulse: got %0d extra pulses want 0", extra);
    end
  endtask

  task automatic test_no_pre_div0;
    int n, pmin, pmax;
    logic [0:127] m, e;
    start_cmd(1'b1, 5'd5, 5'd31, 16'hA5C3, 8'd0, 1'b1);
    vec++;
    if ({mdoEn, mdo} !== 2'b10) begin
      miscmp++;
      $display("FAIL nopre_first_bit: got en/mdo=%b want 10", {mdoEn, mdo});
    end
    wait_rsp(1000, n);
    vec++;
    if (n !== 67) begin
      miscmp++;
      $display("FAIL nopre_latency: got %0d want 67", n);
    end
    vec++;
    if (mon_n - mon_base !== 33) begin
      miscmp++;
      $display("FAIL nopre_mdc_cycles: got %0d want 33", mon_n - mon_base);
    end
    grab(mon_base, 33, -1, m, e, pmin, pmax);
    vec++;
    if (m !== {32'h52FE_A5C3, 96'h0} || e !== {32'hFFFF_FFFF, 96'h0}) begin
      miscmp++;
      $display("FAIL nopre_bits: got %h en %h want %h en %h", m, e, {32'h52FE_A5C3, 96'h0}, {32'hFFFF_FFFF, 96'h0});
    end
    vec++;
    if (pmin !== 2 || pmax !== 2) begin
      miscmp++;
      $display("FAIL nopre_div0_period: got min %0d max %0d want 2", pmin, pmax);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    int n1, n2, pmin, pmax;
    logic [0:127] m, e;
    cmd_write = 1'b1; cmd_phy = 5'd31; cmd_reg = 5'd1; cmd_wdata = 16'h0000;
    cfg_div = 8'd1; cfg_no_pre = 1'b1;
    cmd_valid = 1'b1;
    mon_base = mon_n;
    @(posedge clock); #1;
    vec++;
    if ({busy, cmd_ready} !== 2'b10) begin
      miscmp++;
      $display("FAIL b2b_ready_low: got busy/rdy=%b want 10", {busy, cmd_ready});
    end
    wait_rsp(1000, n1);
    vec++;
    if (n1 !== 67 || cmd_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL b2b_first_rsp: got cycle %0d rdy %b want 67 rdy 1", n1, cmd_ready);
    end
    cmd_phy = 5'd0; cmd_reg = 5'd30; cmd_wdata = 16'hFFFF;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    vec++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin
      miscmp++;
      $display("FAIL b2b_second_accept: got busy/rdy/vld=%b want 100", {busy, cmd_ready, rsp_valid});
    end
    wait_rsp(1000, n2);
    vec++;
    if (n2 !== 67) begin
      miscmp++;
      $display("FAIL b2b_second_latency: got %0d want 67", n2);
    end
    vec++;
    if (mon_n - mon_base !== 66) begin
      miscmp++;
      $display("FAIL b2b_mdc_cycles: got %0d want 66", mon_n - mon_base);
    end
    grab(mon_base, 66, 33, m, e, pmin, pmax);
    vec++;
    if (m !== {32'h5F86_0000, 1'b0, 32'h507A_FFFF, 63'h0} ||
        e !== {32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 63'h0}) begin
      miscmp++;
      $display("FAIL b2b_bits: got %h en %h want %h en %h", m, e,
               {32'h5F86_0000, 1'b0, 32'h507A_FFFF, 63'h0}, {32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 63'h0});
    end
    vec++;
    if (pmin !== 2 || pmax !== 2) begin
      miscmp++;
      $display("FAIL b2b_bit_spacing: got min %0d max %0d want 2", pmin, pmax);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    int k;
    int saw;
    phy_seq = {{46{1'b1}}, 2'b10, 16'h796D, {64{1'b1}}};
    start_cmd(1'b0, 5'd3, 5'd2, 16'h0000, 8'd1, 1'b0);
    k = 0;
    while (mon_n - mon_base < 52 && k < 500) begin
      @(posedge clock); #1;
      k++;
    end
    vec++;
    if (k >= 500) begin
      miscmp++;
      $display("FAIL rst_reach_data: got %0d mdc cycles want 52", mon_n - mon_base);
    end
    #2;
    reset = 1'b0;
    #1;
    vec++;
    if ({mdc, mdoEn, busy, rsp_valid, cmd_ready, mdo} !== 6'b000011) begin
      miscmp++;
      $display("FAIL rst_async_outputs: got mdc/en/busy/vld/rdy/mdo=%b want 000011",
               {mdc, mdoEn, busy, rsp_valid, cmd_ready, mdo});
    end
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1 || mdc === 1'b1) saw++;
    end
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1 || mdc === 1'b1) saw++;
    end
    vec++;
    if (saw !== 0) begin
      miscmp++;
      $display("FAIL rst_abandon: got %0d cycles with rsp_valid/mdc activity want 0", saw);
    end
    check_write_1140("post_reset_write");
  endtask

  initial begin
    test_reset;
    test_write_pre;
    test_read;
    test_no_phy;
    test_no_pre_div0;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
